// File: rtl/can_tx_pkg.sv
// can_tx_pkg: shared frame geometry, frame type and scheduler state encoding
// for the CAN TX mailbox scheduler.
package can_tx_pkg;

  localparam int CAN_FRAME_W = 128;
  localparam int ID_KEY_MSB  = 127;
  localparam int ID_KEY_LSB  = 96;
  localparam int ID_KEY_W    = ID_KEY_MSB - ID_KEY_LSB + 1;

  typedef logic [CAN_FRAME_W-1:0] can_frame_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SELECT = 2'd1,
    REQ    = 2'd2,
    BUSY   = 2'd3
  } tx_state_t;

endpackage

// File: rtl/can_tx_prio_select.sv
// can_tx_prio_select: combinational min-key tree. Picks the valid mailbox
// with the lowest unsigned key; on equal keys the lower index wins because
// the left (lower-index) subtree is kept unless the right one is strictly lower.
module can_tx_prio_select
  import can_tx_pkg::*;
#(
  parameter int NUM_MB = 4
) (
  input  logic [NUM_MB-1:0]          valid,
  input  logic [NUM_MB*ID_KEY_W-1:0] keys,
  output logic [$clog2(NUM_MB)-1:0]  win_idx,
  output logic                       any_valid
);

  localparam int IDX_W  = $clog2(NUM_MB);
  localparam int LEAVES = 1 << IDX_W;

  // Leaves padded to a power of two; padding leaves are never valid.
  logic                leaf_vld [LEAVES];
  logic [ID_KEY_W-1:0] leaf_key [LEAVES];

  genvar gi;
  for (gi = 0; gi < LEAVES; gi++) begin : g_leaf
    if (gi < NUM_MB) begin : g_real
      assign leaf_vld[gi] = valid[gi];
      assign leaf_key[gi] = keys[gi*ID_KEY_W +: ID_KEY_W];
    end else begin : g_pad
      assign leaf_vld[gi] = 1'b0;
      assign leaf_key[gi] = '1;
    end
  end

  // Heap-ordered tree: node n has children 2n and 2n+1, root is node 1.
  logic                t_vld [1:2*LEAVES-1];
  logic [ID_KEY_W-1:0] t_key [1:2*LEAVES-1];
  logic [IDX_W-1:0]    t_idx [1:2*LEAVES-1];

  // Reduce the leaves bottom-up to a single winner at the root.
  always_comb begin
    for (int n = 0; n < LEAVES; n++) begin
      t_vld[LEAVES+n] = leaf_vld[n];
      t_key[LEAVES+n] = leaf_key[n];
      t_idx[LEAVES+n] = IDX_W'(n);
    end
    for (int n = LEAVES - 1; n >= 1; n--) begin
      if (t_vld[2*n+1] && (!t_vld[2*n] || (t_key[2*n+1] < t_key[2*n]))) begin
        t_key[n] = t_key[2*n+1];
        t_idx[n] = t_idx[2*n+1];
      end else begin
        t_key[n] = t_key[2*n];
        t_idx[n] = t_idx[2*n];
      end
      t_vld[n] = t_vld[2*n] | t_vld[2*n+1];
    end
  end

  assign win_idx   = t_idx[1];
  assign any_valid = t_vld[1];

endmodule

// File: rtl/can_tx_mailbox_scheduler.sv
// can_tx_mailbox_scheduler: arbitrates pending TX mailboxes by lowest ID key,
// hands the winner to the transmitter with req/ack and reports the outcome.
// Optional feature macro: CAN_TX_RETRY_LIMIT_EN (drop a mailbox after
// MAX_RETRY consecutive failed attempts; without it retries are unlimited).
module can_tx_mailbox_scheduler
  import can_tx_pkg::*;
#(
  parameter int NUM_MB    = 4,
  parameter int MAX_RETRY = 7
) (
  input  logic                          i_sys_clk,
  input  logic                          i_reset_n,
  input  logic                          i_cen,
  input  logic [NUM_MB-1:0]             i_mb_valid,
  input  logic [NUM_MB*CAN_FRAME_W-1:0] i_mb_data,
  input  logic [NUM_MB-1:0]             i_mb_abort,
  input  logic                          i_tx_ack,
  input  logic                          i_tx_done,
  input  logic                          i_tx_lost,
  input  logic                          i_tx_err,
  output logic                          o_tx_req,
  output logic [CAN_FRAME_W-1:0]        o_tx_data,
  output logic [NUM_MB-1:0]             o_mb_clr,
  output logic [NUM_MB-1:0]             o_mb_fail,
  output logic [NUM_MB-1:0]             o_mb_aborted,
  output logic                          o_busy
);

  localparam int IDX_W = $clog2(NUM_MB);

  can_frame_t                 mb_frame [NUM_MB];
  logic [NUM_MB*ID_KEY_W-1:0] mb_keys;
  logic [IDX_W-1:0]           win_idx;
  logic                       any_valid;

  genvar gi;
  for (gi = 0; gi < NUM_MB; gi++) begin : g_mb
    assign mb_frame[gi]                      = i_mb_data[gi*CAN_FRAME_W +: CAN_FRAME_W];
    assign mb_keys[gi*ID_KEY_W +: ID_KEY_W]  = mb_frame[gi][ID_KEY_MSB:ID_KEY_LSB];
  end

  can_tx_prio_select #(
    .NUM_MB (NUM_MB)
  ) u_prio (
    .valid     (i_mb_valid),
    .keys      (mb_keys),
    .win_idx   (win_idx),
    .any_valid (any_valid)
  );

  tx_state_t         state_reg, state_next;
  logic [IDX_W-1:0]  sel_reg, sel_next;
  can_frame_t        tx_data_reg, tx_data_next;
  logic [NUM_MB-1:0] clr_reg, clr_next;
  logic [NUM_MB-1:0] aborted_reg, aborted_next;
  logic [NUM_MB-1:0] sel_mask;
  logic              abort_sel;

  assign sel_mask  = NUM_MB'(1) << sel_reg;
  assign abort_sel = |(i_mb_abort & sel_mask);

`ifdef CAN_TX_RETRY_LIMIT_EN
  localparam int RETRY_W = $clog2(MAX_RETRY + 1);
  logic [RETRY_W-1:0] retry_reg, retry_next, retry_inc;
  logic [NUM_MB-1:0]  fail_reg, fail_next;

  assign retry_inc = retry_reg + RETRY_W'(1);
`endif

  // Next-state, captured frame and one-cycle result pulses.
  always_comb begin
    state_next   = state_reg;
    sel_next     = sel_reg;
    tx_data_next = tx_data_reg;
    clr_next     = '0;
    aborted_next = '0;
`ifdef CAN_TX_RETRY_LIMIT_EN
    retry_next   = retry_reg;
    fail_next    = '0;
`endif
    case (state_reg)
      IDLE: begin
        if (i_cen && (|i_mb_valid)) state_next = SELECT;
      end
      SELECT: begin
        if (any_valid) begin
          sel_next     = win_idx;
          tx_data_next = mb_frame[win_idx];
          state_next   = REQ;
`ifdef CAN_TX_RETRY_LIMIT_EN
          // The count follows the mailbox that last failed.
          if (win_idx != sel_reg) retry_next = '0;
`endif
        end else begin
          state_next = IDLE;
        end
      end
      REQ: begin
        if (abort_sel) begin
          aborted_next = sel_mask;
          state_next   = IDLE;
        end else if (!i_cen) begin
          state_next = IDLE;
        end else if (i_tx_ack) begin
          state_next = BUSY;
        end
      end
      BUSY: begin
        if (i_tx_done) begin
          clr_next   = sel_mask;
          state_next = IDLE;
`ifdef CAN_TX_RETRY_LIMIT_EN
          retry_next = '0;
`endif
        end else if (i_tx_lost || i_tx_err) begin
          // Returning to IDLE re-arbitrates all mailboxes.
          state_next = IDLE;
          if (abort_sel) begin
            aborted_next = sel_mask;
`ifdef CAN_TX_RETRY_LIMIT_EN
            retry_next   = '0;
`endif
          end else begin
`ifdef CAN_TX_RETRY_LIMIT_EN
            if (retry_inc == RETRY_W'(MAX_RETRY)) begin
              fail_next  = sel_mask;
              retry_next = '0;
            end else begin
              retry_next = retry_inc;
            end
`endif
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Register FSM state, selection, frame and pulses.
  always_ff @(posedge i_sys_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_reg   <= IDLE;
      sel_reg     <= '0;
      tx_data_reg <= '0;
      clr_reg     <= '0;
      aborted_reg <= '0;
    end else begin
      state_reg   <= state_next;
      sel_reg     <= sel_next;
      tx_data_reg <= tx_data_next;
      clr_reg     <= clr_next;
      aborted_reg <= aborted_next;
    end
  end

`ifdef CAN_TX_RETRY_LIMIT_EN
  // Register retry count and the retry-limit pulse.
  always_ff @(posedge i_sys_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      retry_reg <= '0;
      fail_reg  <= '0;
    end else begin
      retry_reg <= retry_next;
      fail_reg  <= fail_next;
    end
  end

  assign o_mb_fail = fail_reg;
`else
  assign o_mb_fail = '0;
`endif

  assign o_tx_req     = (state_reg == REQ);
  assign o_busy       = (state_reg != IDLE);
  assign o_tx_data    = tx_data_reg;
  assign o_mb_clr     = clr_reg;
  assign o_mb_aborted = aborted_reg;

endmodule

// File: doc/can_tx_mailbox_scheduler.md
# can_tx_mailbox_scheduler

Sequences the CAN transmitter on the system clock. It holds up to NUM_MB pending TX mailboxes and picks the highest-priority frame, which is the lowest 32-bit ID key, with ties going to the lowest mailbox index. It presents the chosen frame to the transmitter with a req/ack handshake and tracks the outcome (success, arbitration lost, or error). It re-arbitrates after every attempt, limits retries, and serves abort requests.

## Interface
- NUM_MB, 4, number of mailboxes (2..8)
- MAX_RETRY, 7, failed attempts before a mailbox is dropped (only used with the retry-limit feature)
- i_sys_clk  in  1  system clock; the single clock of the block
- i_reset_n  in  1  asynchronous, active-low reset
- i_cen  in  1  controller enable
- i_mb_valid  in  NUM_MB  mailbox holds a pending frame
- i_mb_data  in  NUM_MB*128  frames; mailbox k occupies bits [128k+127:128k]
- i_mb_abort  in  NUM_MB  abort request, level
- i_tx_ack  in  1  transmitter accepted the frame
- i_tx_done  in  1  pulse: frame sent successfully
- i_tx_lost  in  1  pulse: arbitration lost
- i_tx_err  in  1  pulse: bus error during the frame
- o_tx_req  out  1  frame request to the transmitter
- o_tx_data  out  128  frame being requested or in flight
- o_mb_clr  out  NUM_MB  one-cycle pulse: mailbox sent
- o_mb_fail  out  NUM_MB  one-cycle pulse: retry limit hit
- o_mb_aborted  out  NUM_MB  one-cycle pulse: abort honoured
- o_busy  out  1  high in every state except IDLE

## Operation
- Priority key is frame bits [127:96], compared unsigned; the lower key wins.
- State machine:
  - IDLE: if i_cen is high and any i_mb_valid bit is set, go to SELECT.
  - SELECT: register the winner index (sel) and its frame into o_tx_data, then go to REQ. If no mailbox is valid any more, return to IDLE.
  - REQ: o_tx_req=1.
    - If i_mb_abort[sel] is high: pulse o_mb_aborted[sel] and go to IDLE.
    - Otherwise, if i_cen is low: go to IDLE with no pulse.
    - Otherwise, if i_tx_ack is high: go to BUSY.
  - BUSY: o_tx_req=0; wait for a result.
    - i_tx_done has priority over i_tx_lost and i_tx_err. It pulses o_mb_clr[sel], clears the retry count, and goes to IDLE.
    - On i_tx_lost or i_tx_err with i_mb_abort[sel] high: pulse o_mb_aborted[sel], clear the retry count, go to IDLE.
    - On i_tx_lost or i_tx_err otherwise: increment the retry count and go to IDLE. Going through IDLE re-arbitrates, so a newly valid higher-priority mailbox can win.
- While BUSY, aborts and i_cen=0 are not acted on immediately. An abort is checked only when a result arrives. A low i_cen takes effect after the current frame completes.
- Retry count belongs to the mailbox that last failed. Selecting a different mailbox in SELECT clears the count.
- Aborts on mailboxes other than sel are ignored; the mailbox owner drops i_mb_valid itself.
- i_tx_done, i_tx_lost and i_tx_err outside BUSY are ignored.

## Timing
- Reset values: state=IDLE; o_tx_req=0, o_tx_data=0, o_mb_clr=0, o_mb_fail=0, o_mb_aborted=0, o_busy=0; retry count=0; sel=0.
- Latency: i_mb_valid rising in IDLE raises o_tx_req 2 cycles later (IDLE→SELECT→REQ). o_tx_data is stable from the first o_tx_req cycle until the block leaves BUSY.
- Handshake: o_tx_req stays high until the cycle where i_tx_ack is sampled high. The ack cycle itself goes to BUSY, and o_tx_req is low on the following edge.
- Result pulses (o_mb_clr, o_mb_fail, o_mb_aborted) are registered, appear the cycle after the result input, and last exactly one cycle, coinciding with state=IDLE.
- The next IDLE→SELECT step needs the owner to have dropped i_mb_valid after an o_mb_clr pulse. The owner has 1 cycle to do so; the bench models a 0-cycle owner.
- Reset mid-operation: all state clears immediately; no pulses are generated.

## Configuration
- CAN_TX_RETRY_LIMIT_EN defined:
  - Retry count is $clog2(MAX_RETRY+1) bits.
  - On a lost or error result where the incremented count equals MAX_RETRY: pulse o_mb_fail[sel], clear the count, go to IDLE.
- CAN_TX_RETRY_LIMIT_EN undefined:
  - Retries are unlimited, and the retry counter logic is not built.
  - o_mb_fail is tied to 0.

## Structure
- Package can_tx_pkg holds:
  - the state enum (IDLE, SELECT, REQ, BUSY);
  - CAN_FRAME_W=128, ID_KEY_MSB=127, ID_KEY_LSB=96;
  - a can_frame_t typedef.
- Sub-module can_tx_prio_select: a purely combinational min-key tree over NUM_MB keys and valid bits. Outputs are the winner index and an any_valid flag.

## Test plan
- Priority: valid=4'b0110, keys mb1=0x100, mb2=0x080 → o_tx_data = mb2's frame, o_tx_req 2 cycles after valid; ack then done → o_mb_clr=4'b0100 for one cycle.
- Tie: mb0 and mb3 both have key 0x55 → mb0 is selected.
- Re-arbitration: mb2 (0x200) gets i_tx_lost; mb1 (0x010) becomes valid while BUSY → next request carries mb1.
- Retry limit, macro on, MAX_RETRY=3: mb0 gets 3 consecutive i_tx_err → o_mb_fail=4'b0001 after the third; macro off → 4th request issued, o_mb_fail never pulses.
- Abort: i_mb_abort[sel] in REQ → o_tx_req drops the next cycle, o_mb_aborted pulses. Abort in BUSY with i_tx_done → o_mb_clr pulses, not aborted. Abort in BUSY with i_tx_lost → o_mb_aborted pulses.
- Reset/enable: i_reset_n low in BUSY → all outputs 0, state IDLE; i_cen=0 in REQ → req drops, no pulse.
